// File: rtl/fp16_uint8_converter.sv
// rtl/fp16_uint8_converter.sv - two-stage pipelined fp16 to saturated uint8 converter with valid/ready handshake
module fp16_uint8_converter #(
    parameter int EXP_WIDTH    = 5,
    parameter int FRAC_WIDTH   = 10,
    parameter int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH,
    parameter int EXP_MAX      = 2**EXP_WIDTH - 1,
    parameter int BIAS         = 2**(EXP_WIDTH-1) - 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [FP_WIDTH_REG-1:0] fp16_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [7:0]              uint8_o,
    output logic                    sat_o,
    output logic                    valid_o,
    input  logic                    ready_i
);

    // Mantissa width with hidden bit, largest shift kept, and width of the
    // shift window (mantissa followed by the bits that fall below the point).
    localparam int MW     = FRAC_WIDTH + 1;
    localparam int SH_MAX = 15;
    localparam int WW     = MW + SH_MAX;

    // NEG also covers NaN: both produce 0 with the saturation flag set.
    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NEG  = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NORM = 2'd3
    } cls_t;

    logic                  sign_c;
    logic [EXP_WIDTH-1:0]  exp_c;
    logic [FRAC_WIDTH-1:0] frac_c;
    cls_t                  cls_c;
    logic [3:0]            sh_c;
    logic [MW-1:0]         mant_c;
    logic [WW-1:0]         wide_c;
    logic [MW-1:0]         int_c;
    logic                  guard_c;
    logic                  sticky_c;
    int                    e_int;
    int                    sh_int;

    logic                  v1;
    cls_t                  cls1;
    logic [3:0]            sh1;
    logic [MW-1:0]         int1;
    logic                  guard1;
    logic                  sticky1;
    logic                  v2;

    logic                  adv1;
    logic                  adv2;
    logic                  inc_c;
    logic [MW:0]           rounded_c;
    logic [7:0]            u_c;
    logic                  s_c;

    assign {sign_c, exp_c, frac_c} = fp16_i;

    // Stage 2 drains when empty or when downstream takes it; stage 1 moves
    // whenever stage 2 can take its contents.
    assign adv2    = !v2 || ready_i;
    assign adv1    = !v1 || adv2;
    assign ready_o = adv1;
    assign valid_o = v2;

    // Classify the input and align the mantissa so the integer part, guard
    // and sticky bits are ready for rounding in the next stage.
    always_comb begin
        cls_c  = CLS_ZERO;
        e_int  = 32'(exp_c);
        sh_int = BIAS + FRAC_WIDTH - e_int;
        if (e_int == EXP_MAX && frac_c != '0) begin
            cls_c = CLS_NEG;
        end else if (sign_c && (e_int != 0 || frac_c != '0)) begin
            cls_c = CLS_NEG;
        end else if (e_int == EXP_MAX) begin
            cls_c = CLS_INF;
        end else if (e_int != 0) begin
            cls_c = CLS_NORM;
        end
        if (sh_int < 0) begin
            sh_int = 0;
        end else if (sh_int > SH_MAX) begin
            sh_int = SH_MAX;
        end
        sh_c     = 4'(sh_int);
        mant_c   = {1'b1, frac_c};
        wide_c   = {mant_c, {SH_MAX{1'b0}}} >> sh_c;
        int_c    = wide_c[WW-1:SH_MAX];
        guard_c  = wide_c[SH_MAX-1];
        sticky_c = |wide_c[SH_MAX-2:0];
    end

    // Round half to even and saturate; shift >= 12 means the value is below
    // one half, shift <= 2 means it is at least 256.
    always_comb begin
        inc_c     = guard1 && (sticky1 || int1[0]);
        rounded_c = {1'b0, int1} + {{MW{1'b0}}, inc_c};
        u_c       = 8'd0;
        s_c       = 1'b0;
        case (cls1)
            CLS_ZERO: begin
                u_c = 8'd0;
                s_c = 1'b0;
            end
            CLS_NEG: begin
                u_c = 8'd0;
                s_c = 1'b1;
            end
            CLS_INF: begin
                u_c = 8'd255;
                s_c = 1'b1;
            end
            CLS_NORM: begin
                if (sh1 >= 4'd12) begin
                    u_c = 8'd0;
                    s_c = 1'b0;
                end else if (sh1 <= 4'd2 || rounded_c[MW:8] != '0) begin
                    u_c = 8'd255;
                    s_c = 1'b1;
                end else begin
                    u_c = rounded_c[7:0];
                    s_c = 1'b0;
                end
            end
            default: begin
                u_c = 8'd0;
                s_c = 1'b0;
            end
        endcase
    end

    // Stage 1 register: captures the classified, aligned input on acceptance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1      <= 1'b0;
            cls1    <= CLS_ZERO;
            sh1     <= 4'd0;
            int1    <= '0;
            guard1  <= 1'b0;
            sticky1 <= 1'b0;
        end else if (adv1) begin
            v1 <= valid_i;
            if (valid_i) begin
                cls1    <= cls_c;
                sh1     <= sh_c;
                int1    <= int_c;
                guard1  <= guard_c;
                sticky1 <= sticky_c;
            end
        end
    end

    // Stage 2 register: holds the final result stable while downstream stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v2      <= 1'b0;
            uint8_o <= 8'd0;
            sat_o   <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                uint8_o <= u_c;
                sat_o   <= s_c;
            end
        end
    end

endmodule

// File: tb/tb_fp16_uint8_converter.sv
// tb/tb_fp16_uint8_converter.sv - self-checking bench for fp16_uint8_converter
module tb_fp16_uint8_converter;

    logic        clk_i   = 1'b0;
    logic        rst_ni  = 1'b0;
    logic [15:0] fp16_i  = 16'h0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [7:0]  uint8_o;
    logic        sat_o;
    logic        valid_o;
    logic        ready_i = 1'b1;

    fp16_uint8_converter dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .fp16_i  (fp16_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .uint8_o (uint8_o),
        .sat_o   (sat_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    always #5 clk_i = ~clk_i;

    int n_pass   = 0;
    int n_checks = 0;

    function automatic void check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endfunction

    // Reference: real-valued magnitude, round half to even, clamp. Result is
    // sat*256 + value.
    function automatic int model(input logic [15:0] x);
        int  e;
        int  f;
        int  eff;
        int  r;
        real v;
        real fl;
        real fr;
        e = int'(x[14:10]);
        f = int'(x[9:0]);
        if (e == 31 && f != 0) return 256;
        if (x[15] && (e != 0 || f != 0)) return 256;
        if (e == 31) return 256 + 255;
        v   = (e == 0) ? real'(f) : real'(1024 + f);
        eff = (e == 0) ? 1 : e;
        for (int k = eff; k < 25; k++) v = v / 2.0;
        for (int k = 25; k < eff; k++) v = v * 2.0;
        fl = $floor(v);
        fr = v - fl;
        r  = int'(fl);
        if (fr > 0.5 || (fr == 0.5 && (r % 2) == 1)) r++;
        if (r > 255) return 256 + 255;
        return r;
    endfunction

    // Scoreboard monitor, sampling on the falling edge.
    int          exp_q[$];
    int          out_log[$];
    int          n_out      = 0;
    bit          mon_en     = 1'b0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_u     = 8'h0;
    logic        prev_s     = 1'b0;
    int          exp_v;

    always @(negedge clk_i) begin
        if (mon_en && rst_ni) begin
            if (prev_stall) begin
                check("stall_valid_held", int'(valid_o), 1);
                check("stall_data_held", int'({sat_o, uint8_o}), int'({prev_s, prev_u}));
            end
            if (valid_i && ready_o) exp_q.push_back(model(fp16_i));
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("model_compare", int'({sat_o, uint8_o}), exp_v);
                end
                out_log.push_back(int'(uint8_o));
                n_out++;
            end
            prev_stall = valid_o && !ready_i;
            prev_u     = uint8_o;
            prev_s     = sat_o;
        end else begin
            prev_stall = 1'b0;
        end
    end

    bit rnd_en = 1'b0;

    // Random back-pressure source.
    always begin
        @(posedge clk_i);
        #1;
        if (rnd_en) ready_i = ($urandom_range(7) != 0);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [15:0] x);
        bit acc;
        int guard;
        fp16_i = x;
        valid_i = 1'b1;
        guard = 0;
        acc = 1'b0;
        do begin
            @(negedge clk_i);
            acc = ready_o;
            tick();
            guard++;
        end while (!acc && guard < 1000);
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int guard;
        valid_i = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            tick();
            guard++;
        end
        check("drain_complete", exp_q.size(), 0);
    endtask

    typedef struct {
        logic [15:0] x;
        int          u;
        int          s;
    } vec_t;

    vec_t tbl[15];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int nb;
        int nr;
        int n0;
        int ls;

        tbl[0]  = '{16'h3C00, 1,   0};
        tbl[1]  = '{16'h3800, 0,   0};
        tbl[2]  = '{16'h3A00, 1,   0};
        tbl[3]  = '{16'h3E00, 2,   0};
        tbl[4]  = '{16'h4100, 2,   0};
        tbl[5]  = '{16'h5BF8, 255, 0};
        tbl[6]  = '{16'h5BFC, 255, 1};
        tbl[7]  = '{16'h5C00, 255, 1};
        tbl[8]  = '{16'h7C00, 255, 1};
        tbl[9]  = '{16'h7E00, 0,   1};
        tbl[10] = '{16'hFC00, 0,   1};
        tbl[11] = '{16'hBC00, 0,   1};
        tbl[12] = '{16'h8000, 0,   0};
        tbl[13] = '{16'h0001, 0,   0};
        tbl[14] = '{16'h0000, 0,   0};

        // Reset state
        rst_ni  = 1'b0;
        ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_valid_o", int'(valid_o), 0);
        check("reset_uint8_o", int'(uint8_o), 0);
        check("reset_sat_o", int'(sat_o), 0);
        check("reset_ready_o", int'(ready_o), 1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        @(negedge clk_i);
        check("post_reset_ready_o", int'(ready_o), 1);
        tick();
        mon_en = 1'b1;

        // Class and rounding sweep, isolated samples with latency check
        for (int i = 0; i < 15; i++) begin
            fp16_i  = tbl[i].x;
            valid_i = 1'b1;
            @(negedge clk_i);
            check("sweep_accept", int'(ready_o), 1);
            tick();
            valid_i = 1'b0;
            @(negedge clk_i);
            check("sweep_latency_early", int'(valid_o), 0);
            tick();
            @(negedge clk_i);
            check("sweep_latency", int'(valid_o), 1);
            check($sformatf("sweep_u_%04h", tbl[i].x), int'(uint8_o), tbl[i].u);
            check($sformatf("sweep_s_%04h", tbl[i].x), int'(sat_o), tbl[i].s);
            tick();
        end

        // Exhaustive back-to-back stream
        nb = 0;
        nr = 0;
        n0 = n_out;
        for (int i = 0; i < 65536; i++) begin
            fp16_i  = 16'(i);
            valid_i = 1'b1;
            @(negedge clk_i);
            if (!ready_o) nr++;
            if (i >= 2 && !valid_o) nb++;
            tick();
        end
        drain();
        check("exhaustive_bubbles", nb, 0);
        check("exhaustive_ready_drops", nr, 0);
        check("exhaustive_count", n_out - n0, 65536);

        // Back-pressure: two samples fill the pipe, then ready_o drops
        ls = out_log.size();
        ready_i = 1'b0;
        send(16'h4000);
        send(16'h4200);
        fp16_i  = 16'h4400;
        valid_i = 1'b1;
        @(negedge clk_i);
        check("bp_ready_drop", int'(ready_o), 0);
        check("bp_valid_held", int'(valid_o), 1);
        check("bp_data_held", int'(uint8_o), 2);
        repeat (4) begin
            tick();
            @(negedge clk_i);
            check("bp_stall_data", int'(uint8_o), 2);
            check("bp_stall_ready", int'(ready_o), 0);
        end
        tick();
        ready_i = 1'b1;
        send(16'h4400);
        send(16'h4500);
        drain();
        check("bp_count", out_log.size() - ls, 4);
        for (int k = 0; k < 4; k++) begin
            if (ls + k < out_log.size()) check("bp_order", out_log[ls + k], k + 2);
            else check("bp_order_missing", 0, 1);
        end

        // Random valid/ready toggling
        n0 = n_out;
        rnd_en = 1'b1;
        for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(7) == 0) begin
                valid_i = 1'b0;
                tick();
            end
            send(16'($urandom_range(16'hFFFF)));
        end
        valid_i = 1'b0;
        rnd_en  = 1'b0;
        tick();
        ready_i = 1'b1;
        drain();
        check("random_count", n_out - n0, 10000);

        // Reset with two samples in flight
        ready_i = 1'b0;
        send(16'h4400);
        send(16'h4500);
        valid_i = 1'b0;
        @(negedge clk_i);
        mon_en = 1'b0;
        #2;
        check("mid_reset_pre_valid", int'(valid_o), 1);
        rst_ni = 1'b0;
        #1;
        check("mid_reset_valid_o", int'(valid_o), 0);
        check("mid_reset_uint8_o", int'(uint8_o), 0);
        check("mid_reset_sat_o", int'(sat_o), 0);
        check("mid_reset_ready_o", int'(ready_o), 1);
        exp_q.delete();
        @(negedge clk_i);
        rst_ni  = 1'b1;
        ready_i = 1'b1;
        tick();
        mon_en  = 1'b1;
        fp16_i  = 16'h4900;
        valid_i = 1'b1;
        @(negedge clk_i);
        check("after_reset_accept", int'(ready_o), 1);
        tick();
        valid_i = 1'b0;
        @(negedge clk_i);
        check("after_reset_latency_early", int'(valid_o), 0);
        tick();
        @(negedge clk_i);
        check("after_reset_valid", int'(valid_o), 1);
        check("after_reset_u", int'(uint8_o), 10);
        check("after_reset_s", int'(sat_o), 0);
        tick();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
